// File: rtl/sram_ro_streamer_if.sv
// Signal bundle for sram_ro_streamer: request/status, byte stream and SRAM read-only port.
// The streamer uses the master modport. Its environment (requester, consumer, SRAM) uses slave.
interface sram_ro_streamer_if;
    logic        start;
    logic [7:0]  start_addr;
    logic [8:0]  word_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        sram_ro_csb;
    logic [7:0]  sram_ro_addr;
    logic [31:0] sram_ro_data;

    modport master (
        input  start, start_addr, word_count, abort, byte_ready, sram_ro_data,
        output busy, done, byte_data, byte_valid, sram_ro_csb, sram_ro_addr
    );

    modport slave (
        output start, start_addr, word_count, abort, byte_ready, sram_ro_data,
        input  busy, done, byte_data, byte_valid, sram_ro_csb, sram_ro_addr
    );
endinterface

// File: rtl/sram_ro_streamer.sv
// Reads a block of words through the SRAM read-only port and streams them out LSB byte first,
// using a 2-entry word FIFO so fetches overlap with byte output.
module sram_ro_streamer #(
    parameter int unsigned MAX_WORDS = 256
) (
    input logic                core_clk,
    input logic                core_rstn,
    sram_ro_streamer_if.master bus
);
    localparam logic [8:0] MaxCount = 9'(MAX_WORDS);

    typedef enum logic [1:0] {StIdle, StRead, StCapture} fetch_state_e;

    fetch_state_e state_q, state_d;
    logic [7:0]   addr_q, addr_d;
    logic [8:0]   fetch_left_q, fetch_left_d;
    logic [8:0]   words_left_q, words_left_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  fifo_mem_q [2];
    logic         fifo_wr_q, fifo_wr_d;
    logic         fifo_rd_q, fifo_rd_d;
    logic [1:0]   fifo_cnt_q, fifo_cnt_d;

    logic [31:0]  ser_word_q, ser_word_d;
    logic [1:0]   ser_idx_q, ser_idx_d;
    logic         ser_valid_q, ser_valid_d;

    logic [8:0]   req_count;
    logic         start_ok;
    logic         handshake;
    logic         last_byte;
    logic         capture;
    logic         ser_free;
    logic         pop;
    logic         bypass;
    logic         push;

    always_comb begin
        req_count = (bus.word_count > MaxCount) ? MaxCount : bus.word_count;
        start_ok  = bus.start && !busy_q && !bus.abort;
        handshake = ser_valid_q && bus.byte_ready;
        last_byte = handshake && (ser_idx_q == 2'd3);
        capture   = (state_q == StCapture) && !bus.abort;
        ser_free  = !ser_valid_q || last_byte;
        pop       = ser_free && (fifo_cnt_q != 2'd0);
        // An empty FIFO and an idle serializer take the SRAM word directly, saving a cycle.
        bypass    = ser_free && (fifo_cnt_q == 2'd0) && capture;
        push      = capture && !bypass;
    end

    always_comb begin
        fifo_wr_d  = fifo_wr_q ^ push;
        fifo_rd_d  = fifo_rd_q ^ pop;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        if (bus.abort) begin
            fifo_wr_d  = 1'b0;
            fifo_rd_d  = 1'b0;
            fifo_cnt_d = 2'd0;
        end
    end

    // A new read is issued only if its word will have a FIFO slot when it lands.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        fetch_left_d = fetch_left_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok && (req_count != 9'd0)) begin
                    state_d      = StRead;
                    addr_d       = bus.start_addr;
                    fetch_left_d = req_count - 9'd1;
                end else if (busy_q && (fetch_left_q != 9'd0) && (fifo_cnt_d < 2'd2)) begin
                    state_d      = StRead;
                    fetch_left_d = fetch_left_q - 9'd1;
                end
            end
            StRead: state_d = StCapture;
            StCapture: begin
                addr_d = addr_q + 8'd1;
                if ((fetch_left_q != 9'd0) && (fifo_cnt_d < 2'd2)) begin
                    state_d      = StRead;
                    fetch_left_d = fetch_left_q - 9'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.abort) begin
            state_d      = StIdle;
            fetch_left_d = 9'd0;
        end
    end

    always_comb begin
        ser_word_d  = ser_word_q;
        ser_idx_d   = ser_idx_q;
        ser_valid_d = ser_valid_q;
        if (handshake) begin
            ser_word_d = {8'h00, ser_word_q[31:8]};
            ser_idx_d  = ser_idx_q + 2'd1;
        end
        if (pop) begin
            ser_word_d  = fifo_mem_q[fifo_rd_q];
            ser_idx_d   = 2'd0;
            ser_valid_d = 1'b1;
        end else if (bypass) begin
            ser_word_d  = bus.sram_ro_data;
            ser_idx_d   = 2'd0;
            ser_valid_d = 1'b1;
        end else if (last_byte) begin
            ser_valid_d = 1'b0;
        end
        if (bus.abort) begin
            ser_valid_d = 1'b0;
            ser_idx_d   = 2'd0;
        end
    end

    always_comb begin
        busy_d       = busy_q;
        done_d       = 1'b0;
        words_left_d = words_left_q;
        if (start_ok) begin
            if (req_count == 9'd0) begin
                done_d = 1'b1;
            end else begin
                busy_d       = 1'b1;
                words_left_d = req_count;
            end
        end
        if (last_byte) begin
            words_left_d = words_left_q - 9'd1;
            if (words_left_q == 9'd1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
        if (bus.abort) begin
            busy_d       = 1'b0;
            done_d       = 1'b0;
            words_left_d = 9'd0;
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            state_q       <= StIdle;
            addr_q        <= 8'd0;
            fetch_left_q  <= 9'd0;
            words_left_q  <= 9'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fifo_mem_q[0] <= 32'd0;
            fifo_mem_q[1] <= 32'd0;
            fifo_wr_q     <= 1'b0;
            fifo_rd_q     <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            ser_word_q    <= 32'd0;
            ser_idx_q     <= 2'd0;
            ser_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fetch_left_q <= fetch_left_d;
            words_left_q <= words_left_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            if (push) begin
                fifo_mem_q[fifo_wr_q] <= bus.sram_ro_data;
            end
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_cnt_q   <= fifo_cnt_d;
            ser_word_q   <= ser_word_d;
            ser_idx_q    <= ser_idx_d;
            ser_valid_q  <= ser_valid_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.byte_data    = ser_word_q[7:0];
    assign bus.byte_valid   = ser_valid_q;
    assign bus.sram_ro_csb  = (state_q != StRead);
    assign bus.sram_ro_addr = addr_q;
endmodule

// File: tb/tb_sram_ro_streamer.sv
// Self-checking bench for sram_ro_streamer: an SRAM model, and queues of the expected read
// addresses and bytes that are filled at each start and drained as the DUT produces output.
module tb_sram_ro_streamer;
    logic core_clk = 1'b0;
    logic core_rstn;

    sram_ro_streamer_if bus ();

    sram_ro_streamer #(.MAX_WORDS(256)) dut (
        .core_clk (core_clk),
        .core_rstn(core_rstn),
        .bus      (bus)
    );

    always #5 core_clk = ~core_clk;

    logic [31:0] mem [256];

    // Synchronous SRAM: data is valid in the cycle after the one with csb low.
    always @(posedge core_clk) begin
        bus.sram_ro_data <= !bus.sram_ro_csb ? mem[bus.sram_ro_addr] : 32'hDEAD_BEEF;
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t_start = 0;
    logic [7:0]  byte_exp[$];
    logic [7:0]  addr_exp[$];
    int          n_bytes = 0;
    int          n_reads = 0;
    int          n_done = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    int          done_cyc = 0;
    bit          want_first = 0;
    bit          prev_stall = 0;
    logic [7:0]  prev_data = 8'd0;
    logic        last_valid, last_csb, last_busy, last_done;
    logic        done_busy, done_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sample();
        logic [7:0] e;
        if (prev_stall) begin
            check_eq("hold_valid", 32'(bus.byte_valid), 32'd1);
            check_eq("hold_data", 32'(bus.byte_data), 32'(prev_data));
        end
        prev_stall = bus.byte_valid && !bus.byte_ready;
        prev_data  = bus.byte_data;
        if (!bus.sram_ro_csb) begin
            n_reads++;
            if (addr_exp.size() == 0) begin
                check_eq("unexp_read_csb", 32'(bus.sram_ro_csb), 32'd1);
            end else begin
                e = addr_exp.pop_front();
                check_eq("rd_addr", 32'(bus.sram_ro_addr), 32'(e));
            end
        end
        if (bus.byte_valid && bus.byte_ready) begin
            n_bytes++;
            last_cyc = cyc;
            if (want_first) begin
                first_cyc  = cyc;
                want_first = 0;
            end
            if (byte_exp.size() == 0) begin
                check_eq("unexp_byte_valid", 32'(bus.byte_valid), 32'd0);
            end else begin
                e = byte_exp.pop_front();
                check_eq("byte", 32'(bus.byte_data), 32'(e));
            end
        end
        if (bus.done) begin
            n_done++;
            done_cyc   = cyc;
            done_busy  = bus.busy;
            done_valid = bus.byte_valid;
        end
        last_valid = bus.byte_valid;
        last_csb   = bus.sram_ro_csb;
        last_busy  = bus.busy;
        last_done  = bus.done;
    endtask

    task automatic tick();
        @(negedge core_clk);
        sample();
        @(posedge core_clk);
        #1;
        cyc++;
    endtask

    task automatic start_xfer(input logic [7:0] a, input int unsigned cnt);
        int unsigned n;
        logic [7:0]  wa;
        logic [31:0] w;
        n = (cnt > 256) ? 256 : cnt;
        for (int i = 0; i < int'(n); i++) begin
            wa = a + 8'(i);
            addr_exp.push_back(wa);
            w = mem[wa];
            for (int b = 0; b < 4; b++) byte_exp.push_back(w[8*b +: 8]);
        end
        bus.start      = 1'b1;
        bus.start_addr = a;
        bus.word_count = 9'(cnt);
        t_start        = cyc;
        want_first     = 1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int base = n_done;
        int k = 0;
        while (n_done == base && k < budget) begin
            tick();
            k++;
        end
        check_eq("done_seen", 32'(n_done - base), 32'd1);
    endtask

    task automatic check_drained(input string tag);
        check_eq({tag, "_bytes_left"}, 32'(byte_exp.size()), 32'd0);
        check_eq({tag, "_reads_left"}, 32'(addr_exp.size()), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_valid", 32'(bus.byte_valid), 32'd0);
        check_eq("rst_data", 32'(bus.byte_data), 32'd0);
        check_eq("rst_csb", 32'(bus.sram_ro_csb), 32'd1);
        check_eq("rst_addr", 32'(bus.sram_ro_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, by0, dn0, k;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i) ^ 8'h3C, 8'(i) + 8'h11, ~8'(i), 8'(i)};
        end
        mem[8'h10] = 32'hDDCCBBAA;
        core_rstn      = 1'b0;
        bus.start      = 1'b0;
        bus.start_addr = 8'd0;
        bus.word_count = 9'd0;
        bus.abort      = 1'b0;
        bus.byte_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs();
        core_rstn = 1'b1;
        repeat (2) tick();

        // Single word: csb at T+1, bytes T+3..T+6, done at T+7.
        rd0 = n_reads;
        start_xfer(8'h10, 1);
        tick();
        check_eq("t1_busy", 32'(last_busy), 32'd1);
        check_eq("t1_csb", 32'(last_csb), 32'd0);
        wait_done(20);
        check_eq("single_first", 32'(first_cyc), 32'(t_start + 3));
        check_eq("single_last", 32'(last_cyc), 32'(t_start + 6));
        check_eq("single_done", 32'(done_cyc), 32'(t_start + 7));
        check_eq("done_busy", 32'(done_busy), 32'd0);
        check_eq("done_valid", 32'(done_valid), 32'd0);
        check_eq("single_reads", 32'(n_reads - rd0), 32'd1);
        check_drained("single");
        tick();

        // Streaming: 12 bytes back to back.
        rd0 = n_reads;
        by0 = n_bytes;
        start_xfer(8'h00, 3);
        wait_done(40);
        check_eq("stream_first", 32'(first_cyc), 32'(t_start + 3));
        check_eq("stream_last", 32'(last_cyc), 32'(t_start + 14));
        check_eq("stream_done", 32'(done_cyc), 32'(t_start + 15));
        check_eq("stream_bytes", 32'(n_bytes - by0), 32'd12);
        check_eq("stream_reads", 32'(n_reads - rd0), 32'd3);
        check_drained("stream");
        tick();

        // Backpressure: consumer stalls for 10 cycles after the first byte.
        rd0 = n_reads;
        by0 = n_bytes;
        start_xfer(8'h40, 4);
        k = 0;
        while (n_bytes == by0 && k < 20) begin
            tick();
            k++;
        end
        bus.byte_ready = 1'b0;
        repeat (10) tick();
        check_eq("bp_reads_stalled", 32'(n_reads - rd0), 32'd3);
        check_eq("bp_bytes_stalled", 32'(n_bytes - by0), 32'd1);
        bus.byte_ready = 1'b1;
        wait_done(60);
        check_eq("bp_bytes", 32'(n_bytes - by0), 32'd16);
        check_eq("bp_reads", 32'(n_reads - rd0), 32'd4);
        check_drained("bp");
        tick();

        // Address wrap 0xFE, 0xFF, 0x00.
        start_xfer(8'hFE, 3);
        wait_done(40);
        check_drained("wrap");
        tick();

        // Zero-length request: done at T+1, no read, never busy.
        rd0 = n_reads;
        dn0 = n_done;
        start_xfer(8'h33, 0);
        tick();
        check_eq("zero_done", 32'(last_done), 32'd1);
        check_eq("zero_busy", 32'(last_busy), 32'd0);
        tick();
        check_eq("zero_done_pulse", 32'(last_done), 32'd0);
        check_eq("zero_done_count", 32'(n_done - dn0), 32'd1);
        check_eq("zero_reads", 32'(n_reads - rd0), 32'd0);

        // Start while busy must not disturb the transfer in progress.
        rd0 = n_reads;
        dn0 = n_done;
        start_xfer(8'h20, 3);
        tick();
        tick();
        bus.start      = 1'b1;
        bus.start_addr = 8'h80;
        bus.word_count = 9'd5;
        tick();
        bus.start = 1'b0;
        wait_done(60);
        repeat (4) tick();
        check_eq("ign_reads", 32'(n_reads - rd0), 32'd3);
        check_eq("ign_done", 32'(n_done - dn0), 32'd1);
        check_drained("ign");

        // Abort after the 5th byte of a 4-word transfer.
        by0 = n_bytes;
        dn0 = n_done;
        start_xfer(8'h30, 4);
        k = 0;
        while (n_bytes - by0 < 5 && k < 30) begin
            tick();
            k++;
        end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.start_addr = 8'h90;
        bus.word_count = 9'd2;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        byte_exp.delete();
        addr_exp.delete();
        rd0 = n_reads;
        tick();
        check_eq("abort_valid", 32'(last_valid), 32'd0);
        check_eq("abort_csb", 32'(last_csb), 32'd1);
        check_eq("abort_busy", 32'(last_busy), 32'd0);
        repeat (10) tick();
        check_eq("abort_no_done", 32'(n_done - dn0), 32'd0);
        check_eq("abort_no_reads", 32'(n_reads - rd0), 32'd0);
        start_xfer(8'h50, 2);
        wait_done(40);
        check_eq("after_abort_first", 32'(first_cyc), 32'(t_start + 3));
        check_drained("after_abort");
        tick();

        // Asynchronous reset mid-stream.
        by0 = n_bytes;
        dn0 = n_done;
        start_xfer(8'h60, 8);
        k = 0;
        while (n_bytes - by0 < 6 && k < 30) begin
            tick();
            k++;
        end
        core_rstn = 1'b0;
        #1;
        check_reset_outputs();
        byte_exp.delete();
        addr_exp.delete();
        repeat (3) tick();
        core_rstn = 1'b1;
        repeat (5) tick();
        check_eq("rst_no_done", 32'(n_done - dn0), 32'd0);
        start_xfer(8'h70, 1);
        wait_done(20);
        check_eq("after_rst_done", 32'(done_cyc), 32'(t_start + 7));
        check_drained("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
